// File: rtl/decode_queue.sv
// decode_queue: RV32I decode stage feeding a DEPTH-entry queue of decoded
// instructions. Each entry holds the PC, the raw word and the control bundle.
// Optional feature: define DECODE_M_EXT_EN to decode the M extension
// (funct7 = 0x01). Otherwise those encodings are reported as illegal.
//
// Handshake (both ports): a transfer happens on a rising clk edge where
// valid and ready are both high. valid never waits on ready. in_ready is a
// function of count and flush only, so it has no path from out_ready.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_inst,
    input  logic [PC_W-1:0]         in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic [2:0]              out_imm_sel,
    output logic [2:0]              out_cmp_ctrl,
    output logic [3:0]              out_alu_ctrl,
    output logic                    out_is_br,
    output logic                    out_is_jal,
    output logic                    out_is_jalr,
    output logic                    out_alu_src_a,
    output logic                    out_alu_src_b,
    output logic                    out_data_to_reg,
    output logic                    out_reg_write,
    output logic                    out_mem_w,
    output logic                    out_mio,
    output logic                    out_rs1use,
    output logic                    out_rs2use,
    output logic [1:0]              out_hazard_optype,
    output logic                    out_illegal,
    output logic                    out_is_md,
    output logic [2:0]              out_md_op,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Opcodes
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_L     = 7'h03;
    localparam logic [6:0] OP_S     = 7'h23;
    localparam logic [6:0] OP_B     = 7'h63;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6f;
    localparam logic [6:0] OP_JALR  = 7'h67;

    // Immediate selects
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_S = 3'b100;
    localparam logic [2:0] IMM_U = 3'b101;

    // Branch comparisons
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_NE  = 3'b010;
    localparam logic [2:0] CMP_LT  = 3'b011;
    localparam logic [2:0] CMP_LTU = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_GEU = 3'b110;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_AP4  = 4'b1011;
    localparam logic [3:0] ALU_BOUT = 4'b1100;

    localparam logic [1:0] HZ_ALU   = 2'b01;
    localparam logic [1:0] HZ_LOAD  = 2'b10;
    localparam logic [1:0] HZ_STORE = 2'b11;

    typedef struct packed {
        logic [2:0] imm_sel;
        logic [2:0] cmp_ctrl;
        logic [3:0] alu_ctrl;
        logic       is_br;
        logic       is_jal;
        logic       is_jalr;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       data_to_reg;
        logic       reg_write;
        logic       mem_w;
        logic       mio;
        logic       rs1use;
        logic       rs2use;
        logic [1:0] hazard_optype;
        logic       illegal;
        logic       is_md;
        logic [2:0] md_op;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;
    ctrl_t      dec;
    ctrl_t      head;

    logic [PC_W-1:0] pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    ctrl_t           ctrl_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic          push;
    logic          pop;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    // Combinational decode of the incoming word; illegal words collapse to a
    // bundle with only the illegal flag set so issue can raise the trap.
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OP_R: begin
                dec.reg_write     = 1'b1;
                dec.rs1use        = 1'b1;
                dec.rs2use        = 1'b1;
                dec.hazard_optype = HZ_ALU;
                if (f7 == 7'h00) begin
                    case (f3)
                        3'b000:  dec.alu_ctrl = ALU_ADD;
                        3'b001:  dec.alu_ctrl = ALU_SLL;
                        3'b010:  dec.alu_ctrl = ALU_SLT;
                        3'b011:  dec.alu_ctrl = ALU_SLTU;
                        3'b100:  dec.alu_ctrl = ALU_XOR;
                        3'b101:  dec.alu_ctrl = ALU_SRL;
                        3'b110:  dec.alu_ctrl = ALU_OR;
                        default: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (f7 == 7'h20) begin
                    if (f3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
                    else if (f3 == 3'b101) dec.alu_ctrl = ALU_SRA;
                    else                   legal = 1'b0;
                end
`ifdef DECODE_M_EXT_EN
                else if (f7 == 7'h01) begin
                    // Multiply/divide unit takes the op from md_op; ALU idle.
                    dec.is_md    = 1'b1;
                    dec.md_op    = f3;
                    dec.alu_ctrl = 4'b0000;
                end
`endif
                else begin
                    legal = 1'b0;
                end
            end
            OP_I: begin
                dec.imm_sel       = IMM_I;
                dec.alu_src_b     = 1'b1;
                dec.reg_write     = 1'b1;
                dec.rs1use        = 1'b1;
                dec.hazard_optype = HZ_ALU;
                case (f3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        if (f7 != 7'h00) legal = 1'b0;
                    end
                    default: begin
                        if (f7 == 7'h00)      dec.alu_ctrl = ALU_SRL;
                        else if (f7 == 7'h20) dec.alu_ctrl = ALU_SRA;
                        else                  legal = 1'b0;
                    end
                endcase
            end
            OP_L: begin
                dec.imm_sel       = IMM_I;
                dec.alu_ctrl      = ALU_ADD;
                dec.alu_src_b     = 1'b1;
                dec.data_to_reg   = 1'b1;
                dec.reg_write     = 1'b1;
                dec.mio           = 1'b1;
                dec.rs1use        = 1'b1;
                dec.hazard_optype = HZ_LOAD;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) legal = 1'b0;
            end
            OP_S: begin
                dec.imm_sel       = IMM_S;
                dec.alu_ctrl      = ALU_ADD;
                dec.alu_src_b     = 1'b1;
                dec.mem_w         = 1'b1;
                dec.mio           = 1'b1;
                dec.rs1use        = 1'b1;
                dec.rs2use        = 1'b1;
                dec.hazard_optype = HZ_STORE;
                if (f3 > 3'b010) legal = 1'b0;
            end
            OP_B: begin
                // Branch target and resolution are computed downstream.
                dec.imm_sel = IMM_B;
                dec.is_br   = 1'b1;
                dec.rs1use  = 1'b1;
                dec.rs2use  = 1'b1;
                case (f3)
                    3'b000:  dec.cmp_ctrl = CMP_EQ;
                    3'b001:  dec.cmp_ctrl = CMP_NE;
                    3'b100:  dec.cmp_ctrl = CMP_LT;
                    3'b101:  dec.cmp_ctrl = CMP_GE;
                    3'b110:  dec.cmp_ctrl = CMP_LTU;
                    3'b111:  dec.cmp_ctrl = CMP_GEU;
                    default: legal = 1'b0;
                endcase
            end
            OP_LUI: begin
                dec.imm_sel       = IMM_U;
                dec.alu_ctrl      = ALU_BOUT;
                dec.alu_src_b     = 1'b1;
                dec.reg_write     = 1'b1;
                dec.hazard_optype = HZ_ALU;
            end
            OP_AUIPC: begin
                dec.imm_sel       = IMM_U;
                dec.alu_ctrl      = ALU_ADD;
                dec.alu_src_a     = 1'b1;
                dec.alu_src_b     = 1'b1;
                dec.reg_write     = 1'b1;
                dec.hazard_optype = HZ_ALU;
            end
            OP_JAL: begin
                // Link value is PC+4 through the ALU.
                dec.imm_sel       = IMM_J;
                dec.alu_ctrl      = ALU_AP4;
                dec.is_jal        = 1'b1;
                dec.alu_src_a     = 1'b1;
                dec.reg_write     = 1'b1;
                dec.hazard_optype = HZ_ALU;
            end
            OP_JALR: begin
                dec.imm_sel       = IMM_I;
                dec.alu_ctrl      = ALU_AP4;
                dec.is_jalr       = 1'b1;
                dec.alu_src_a     = 1'b1;
                dec.reg_write     = 1'b1;
                dec.rs1use        = 1'b1;
                dec.hazard_optype = HZ_ALU;
                if (f3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // No push into a full queue and nothing enters during a flush.
    assign in_ready  = (cnt_q < CW'(DEPTH)) && !flush;
    assign out_valid = (cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt_q;

    // Pointer and occupancy bookkeeping; flush wins over any push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

    // Entry storage is written at the tail and is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            ctrl_mem[wr_ptr] <= dec;
        end
    end

    // Head presentation; every field reads zero while the queue is empty.
    always_comb begin
        head     = '0;
        out_pc   = '0;
        out_inst = '0;
        if (out_valid) begin
            head     = ctrl_mem[rd_ptr];
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
        end
    end

    assign out_imm_sel       = head.imm_sel;
    assign out_cmp_ctrl      = head.cmp_ctrl;
    assign out_alu_ctrl      = head.alu_ctrl;
    assign out_is_br         = head.is_br;
    assign out_is_jal        = head.is_jal;
    assign out_is_jalr       = head.is_jalr;
    assign out_alu_src_a     = head.alu_src_a;
    assign out_alu_src_b     = head.alu_src_b;
    assign out_data_to_reg   = head.data_to_reg;
    assign out_reg_write     = head.reg_write;
    assign out_mem_w         = head.mem_w;
    assign out_mio           = head.mio;
    assign out_rs1use        = head.rs1use;
    assign out_rs2use        = head.rs2use;
    assign out_hazard_optype = head.hazard_optype;
    assign out_illegal       = head.illegal;
    assign out_is_md         = head.is_md;
    assign out_md_op         = head.md_op;

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue (DEPTH=4, PC_W=32).
// Build with +define+DECODE_M_EXT_EN to exercise the M-extension decode.
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int NV    = 25;
    localparam int W     = 92;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_sel;
    logic [2:0]  out_cmp_ctrl;
    logic [3:0]  out_alu_ctrl;
    logic        out_is_br;
    logic        out_is_jal;
    logic        out_is_jalr;
    logic        out_alu_src_a;
    logic        out_alu_src_b;
    logic        out_data_to_reg;
    logic        out_reg_write;
    logic        out_mem_w;
    logic        out_mio;
    logic        out_rs1use;
    logic        out_rs2use;
    logic [1:0]  out_hazard_optype;
    logic        out_illegal;
    logic        out_is_md;
    logic [2:0]  out_md_op;
    logic [2:0]  count;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm_sel(out_imm_sel), .out_cmp_ctrl(out_cmp_ctrl), .out_alu_ctrl(out_alu_ctrl),
        .out_is_br(out_is_br), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
        .out_alu_src_a(out_alu_src_a), .out_alu_src_b(out_alu_src_b),
        .out_data_to_reg(out_data_to_reg), .out_reg_write(out_reg_write),
        .out_mem_w(out_mem_w), .out_mio(out_mio), .out_rs1use(out_rs1use),
        .out_rs2use(out_rs2use), .out_hazard_optype(out_hazard_optype),
        .out_illegal(out_illegal), .out_is_md(out_is_md), .out_md_op(out_md_op),
        .count(count)
    );

    // Vector: instruction word and the expected 28-bit control tuple
    // {imm, cmp, alu, br jal jalr sa sb d2r rw mw mio r1 r2, hz, ill, md, md_op}.
    typedef struct packed {
        logic [31:0] inst;
        logic [27:0] ctrl;
    } vec_t;

    vec_t        vecs [NV];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] drv_exp;
    int          n_cmp;
    int          n_fail;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [27:0] mk(input logic [2:0] imm, input logic [2:0] cmp,
                                       input logic [3:0] alu, input logic [10:0] fl,
                                       input logic [1:0] hz, input logic ill,
                                       input logic md, input logic [2:0] op);
        return {imm, cmp, alu, fl, hz, ill, md, op};
    endfunction

    function automatic logic [W-1:0] pack_out();
        return {out_pc, out_inst, out_imm_sel, out_cmp_ctrl, out_alu_ctrl,
                out_is_br, out_is_jal, out_is_jalr, out_alu_src_a, out_alu_src_b,
                out_data_to_reg, out_reg_write, out_mem_w, out_mio, out_rs1use,
                out_rs2use, out_hazard_optype, out_illegal, out_is_md, out_md_op};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // Sampled at the falling edge; decides what the coming rising edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            check("count", 96'(count), 96'(exp_q.size()));
            check("in_ready", 96'(in_ready), 96'((exp_q.size() < DEPTH) && !flush));
            check("out_valid", 96'(out_valid), 96'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) check("head", 96'(pack_out()), 96'(exp_q[0]));
            else if (!out_valid) check("idle_zero", 96'(pack_out()), 96'(0));
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) exp_q.push_back(drv_exp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_vec(input int idx, input logic [31:0] pc);
        in_inst = vecs[idx].inst;
        in_pc   = pc;
        drv_exp = {pc, vecs[idx].inst, vecs[idx].ctrl};
    endtask

    task automatic push_vec(input int idx, input logic [31:0] pc);
        bit done;
        done = 1'b0;
        set_vec(idx, pc);
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        check("push_accept", 96'(done), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_done", 96'(exp_q.size()), 96'(0));
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'($urandom_range(0, 16383)) << 2;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [27:0] ill;
        bit done;
        ill = mk(3'b000, 3'b000, 4'b0000, 11'b0, 2'b00, 1'b1, 1'b0, 3'b000);
        vecs[0]  = '{32'h00500093, mk(3'b001, 3'b000, 4'b0001, 11'b00001010010, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[1]  = '{32'h002081B3, mk(3'b000, 3'b000, 4'b0001, 11'b00000010011, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[2]  = '{32'h402081B3, mk(3'b000, 3'b000, 4'b0010, 11'b00000010011, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[3]  = '{32'h4020D1B3, mk(3'b000, 3'b000, 4'b1010, 11'b00000010011, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[4]  = '{32'h0020B1B3, mk(3'b000, 3'b000, 4'b1001, 11'b00000010011, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[5]  = '{32'h0080A283, mk(3'b001, 3'b000, 4'b0001, 11'b00001110110, 2'b10, 1'b0, 1'b0, 3'b000)};
        vecs[6]  = '{32'h0020A623, mk(3'b100, 3'b000, 4'b0001, 11'b00001001111, 2'b11, 1'b0, 1'b0, 3'b000)};
        vecs[7]  = '{32'h00208663, mk(3'b010, 3'b001, 4'b0000, 11'b10000000011, 2'b00, 1'b0, 1'b0, 3'b000)};
        vecs[8]  = '{32'h0020F663, mk(3'b010, 3'b110, 4'b0000, 11'b10000000011, 2'b00, 1'b0, 1'b0, 3'b000)};
        vecs[9]  = '{32'h123450B7, mk(3'b101, 3'b000, 4'b1100, 11'b00001010000, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[10] = '{32'h00001097, mk(3'b101, 3'b000, 4'b0001, 11'b00011010000, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[11] = '{32'h008000EF, mk(3'b011, 3'b000, 4'b1011, 11'b01010010000, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[12] = '{32'h000100E7, mk(3'b001, 3'b000, 4'b1011, 11'b00110010010, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[13] = '{32'h0000000F, ill};
        vecs[14] = '{32'h00000073, ill};
        vecs[15] = '{32'h202081B3, ill};
        vecs[16] = '{32'h00309093, mk(3'b001, 3'b000, 4'b0110, 11'b00001010010, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[17] = '{32'h4030D093, mk(3'b001, 3'b000, 4'b1010, 11'b00001010010, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[18] = '{32'h0020A663, ill};
`ifdef DECODE_M_EXT_EN
        vecs[19] = '{32'h022080B3, mk(3'b000, 3'b000, 4'b0000, 11'b00000010011, 2'b01, 1'b0, 1'b1, 3'b000)};
        vecs[20] = '{32'h0220F0B3, mk(3'b000, 3'b000, 4'b0000, 11'b00000010011, 2'b01, 1'b0, 1'b1, 3'b111)};
`else
        vecs[19] = '{32'h022080B3, ill};
        vecs[20] = '{32'h0220F0B3, ill};
`endif
        vecs[21] = '{32'h00000000, ill};
        vecs[22] = '{32'h0040C093, mk(3'b001, 3'b000, 4'b0101, 11'b00001010010, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[23] = '{32'h0020E1B3, mk(3'b000, 3'b000, 4'b0100, 11'b00000010011, 2'b01, 1'b0, 1'b0, 3'b000)};
        vecs[24] = '{32'h402091B3, ill};

        n_cmp = 0; n_fail = 0;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0; drv_exp = '0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_count", 96'(count), 96'(0));
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_bundle", 96'(pack_out()), 96'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 96'(in_ready), 96'(1));
        @(posedge clk); #1;

        // addi into an empty queue, held so the head is inspected
        push_vec(0, 32'h100);
        @(negedge clk);
        check("addi_valid", 96'(out_valid), 96'(1));
        check("addi_pc", 96'(out_pc), 96'(32'h100));
        check("addi_alu", 96'(out_alu_ctrl), 96'(4'b0001));
        check("addi_imm", 96'(out_imm_sel), 96'(3'b001));
        check("addi_src_b", 96'(out_alu_src_b), 96'(1));
        check("addi_rw", 96'(out_reg_write), 96'(1));
        check("addi_hz", 96'(out_hazard_optype), 96'(2'b01));
        @(posedge clk); #1;
        drain();

        // Whole table streamed back-to-back with issue always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) push_vec(i, rand_pc());
        drain();

        // Fill to DEPTH, 5th held until a slot frees
        for (int i = 0; i < DEPTH; i++) push_vec(i + 1, rand_pc());
        @(negedge clk);
        check("full_count", 96'(count), 96'(DEPTH));
        check("full_in_ready", 96'(in_ready), 96'(0));
        @(posedge clk); #1;
        set_vec(5, rand_pc());
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("held_in_ready", 96'(in_ready), 96'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        check("fifth_accept", 96'(done), 96'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        // Second fill wraps the pointers
        for (int i = 0; i < DEPTH; i++) push_vec(i + 6, rand_pc());
        drain();

        // count=2 with simultaneous push/pop, then flush with a push pending
        push_vec(9, rand_pc());
        push_vec(10, rand_pc());
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_vec(i + 11, rand_pc());
            in_valid = 1'b1;
            @(negedge clk);
            check("steady_count", 96'(count), 96'(2));
            @(posedge clk); #1;
        end
        set_vec(0, 32'h200);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("flush_count", 96'(count), 96'(0));
        check("flush_valid", 96'(out_valid), 96'(0));
        @(posedge clk); #1;

        // beq then fence
        push_vec(7, rand_pc());
        push_vec(13, rand_pc());
        @(negedge clk);
        check("beq_is_br", 96'(out_is_br), 96'(1));
        check("beq_cmp", 96'(out_cmp_ctrl), 96'(3'b001));
        check("beq_rs2use", 96'(out_rs2use), 96'(1));
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        check("fence_illegal", 96'(out_illegal), 96'(1));
        check("fence_rw", 96'(out_reg_write), 96'(0));
        @(posedge clk); #1;
        drain();

        // mul
        push_vec(19, rand_pc());
        @(negedge clk);
`ifdef DECODE_M_EXT_EN
        check("mul_is_md", 96'(out_is_md), 96'(1));
        check("mul_md_op", 96'(out_md_op), 96'(3'b000));
        check("mul_illegal", 96'(out_illegal), 96'(0));
`else
        check("mul_illegal", 96'(out_illegal), 96'(1));
        check("mul_is_md", 96'(out_is_md), 96'(0));
`endif
        @(posedge clk); #1;
        drain();

        // Random traffic with occasional flush
        for (int i = 0; i < 120; i++) begin
            set_vec(int'($urandom_range(0, NV - 1)), rand_pc());
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0; in_valid = 1'b0;
        drain();

        // Asynchronous reset mid-stream with three entries queued
        for (int i = 0; i < 3; i++) push_vec(i + 2, rand_pc());
        @(negedge clk);
        check("pre_rst_count", 96'(count), 96'(3));
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 96'(count), 96'(0));
        check("async_rst_valid", 96'(out_valid), 96'(0));
        check("async_rst_bundle", 96'(pack_out()), 96'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 96'(in_ready), 96'(1));
        @(posedge clk); #1;
        push_vec(22, rand_pc());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised RV32I decode stage with a decoded-instruction queue between instruction fetch and issue. Instructions arrive over a valid/ready handshake, are decoded combinationally into the core's control bundle, and are stored with their PC in a DEPTH-entry FIFO. The head entry is presented to issue over a second valid/ready handshake. Adds illegal-instruction detection, pipeline flush and an optional M-extension decode.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- PC_W, 32, PC width
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous queue clear (branch mispredict / trap)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept an instruction
- in_inst  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  head entry valid
- out_ready  in  1  issue consumes the head
- out_pc, out_inst  out  PC_W, 32  head PC and raw word
- out_imm_sel  out  3  I=001 B=010 J=011 S=100 U=101, none=000
- out_cmp_ctrl  out  3  EQ=001 NE=010 LT=011 LTU=100 GE=101 GEU=110
- out_alu_ctrl  out  4  ADD=0001 SUB=0010 AND=0011 OR=0100 XOR=0101 SLL=0110 SRL=0111 SLT=1000 SLTU=1001 SRA=1010 Ap4=1011 Bout=1100
- out_is_br, out_is_jal, out_is_jalr  out  1 each  control-transfer class; branch resolution stays downstream
- out_alu_src_a, out_alu_src_b, out_data_to_reg, out_reg_write, out_mem_w, out_mio, out_rs1use, out_rs2use  out  1 each  same meaning as the core control signals
- out_hazard_optype  out  2  ALU=01 LOAD=10 STORE=11, none=00
- out_illegal  out  1  undecodable instruction
- out_is_md, out_md_op  out  1, 3  M-extension op (see Configuration)
- count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Decode is combinational on in_inst.
  - Covers the RV32I R/I/B/L/S/LUI/AUIPC/JAL/JALR classes.
  - Field encodings are as listed in Interface.
  - ALU codes: ADD is used for L, S and AUIPC. Ap4 is used for JAL/JALR. Bout is used for LUI.
- Illegal instruction: any opcode/funct3/funct7 combination outside the decoded set. This includes FENCE, SYSTEM and funct7 not 0x00/0x20 (or not 0x01 when the M-extension is enabled).
  - out_illegal=1.
  - reg_write, mem_w, mio, rs1use and rs2use are forced to 0.
  - alu_ctrl, imm_sel, cmp_ctrl and hazard_optype are 000/0000.
  - The entry is still queued so issue can raise the trap.
- Push occurs when in_valid & in_ready. The decoded bundle, in_pc and in_inst are written at the tail.
- Pop occurs when out_valid & out_ready. The head pointer advances.
- in_ready = (count < DEPTH) & ~flush. There is no push into a full queue, even if a pop happens in the same cycle.
- out_valid = (count != 0).
- All out_* bundle fields are forced to 0 when out_valid=0. FIFO storage itself is not reset.
- Simultaneous push and pop when count in 1..DEPTH-1: count is unchanged and both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush=1: next cycle count=0 and both pointers=0. Any push or pop in the flush cycle is discarded.

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, out_valid=0, all out_* fields=0, in_ready=1 after release.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N is visible on out_* after edge N, with out_valid=1 in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle, sustained.
- in_ready depends only on count and flush. It is never combinationally dependent on out_ready.
- out_valid, once high, stays high until the pop or flush. The head contents are stable while out_valid & ~out_ready.

## Configuration
- Macro DECODE_M_EXT_EN.
- Defined: R-type with funct7=0x01 decodes with out_is_md=1, reg_write=1, rs1use=1, rs2use=1, hazard_optype=01 and alu_ctrl=0000. out_md_op=funct3, mapping MUL=000 through REMU=111.
- Undefined: these encodings are illegal, and out_is_md and out_md_op are tied to 0.

## Test plan
- Reset with rst_n=0 mid-stream while count=3 -> count=0 and out_valid=0 immediately; after release in_ready=1.
- Push 0x00500093 (addi x1,x0,5) at pc=0x100 into an empty queue -> next cycle out_valid=1, out_alu_ctrl=0001, out_imm_sel=001, out_alu_src_b=1, out_reg_write=1, out_hazard_optype=01, out_pc=0x100.
- DEPTH=4 with out_ready=0 and 5 pushes attempted -> in_ready=0 at count=4; the 5th is held; pops return the 4 entries in order, with pointer wrap on a second fill.
- count=2 with simultaneous push and pop for 10 cycles -> count stays 2 and order is preserved; then flush together with in_valid=1 -> count=0 next cycle and the pushed word is discarded.
- Push 0x00208663 (beq x1,x2,+12), then 0x0000000F (fence) -> first entry has out_is_br=1, out_cmp_ctrl=001, out_rs2use=1; second has out_illegal=1 and out_reg_write=0.
- Push 0x022080B3 (mul x1,x1,x2) -> with DECODE_M_EXT_EN: out_is_md=1, out_md_op=000, out_illegal=0; without it: out_illegal=1.
